// File: rtl/uart_tx_scheduler.sv
// UART transmit sequencer. It pops the TX FIFO, holds each byte on DOUT for its whole frame,
// drives TXSTART for START_HOLD baud ticks, and counts the stop bits to produce THRE/TEMT/THRI.
// Latency: FIFO_RD and TXSTART rise on the edge after GO is seen. Back-to-back pops follow TXFINISHED by one cycle.
// Backpressure: with AFE=1, CTS low or CLEAR blocks new pops only. A frame that has started always runs to completion.
// Ports: CLK/RST (async active-high); TXCLK baud tick; WLS/STB frame format; AFE/CTS flow control;
//        FIFO_EMPTY/FIFO_DATA/FIFO_RD/CLEAR FIFO side; TXFINISHED/TXSTART/DOUT transmitter side;
//        THRE/TEMT/THRI status to the register block.
module uart_tx_scheduler #(
    parameter int DW         = 8,
    parameter int START_HOLD = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          TXCLK,
    input  logic [1:0]    WLS,
    input  logic          STB,
    input  logic          AFE,
    input  logic          CTS,
    input  logic          FIFO_EMPTY,
    input  logic [DW-1:0] FIFO_DATA,
    output logic          FIFO_RD,
    input  logic          CLEAR,
    input  logic          TXFINISHED,
    output logic          TXSTART,
    output logic [DW-1:0] DOUT,
    output logic          THRE,
    output logic          TEMT,
    output logic          THRI
);

    localparam int HW = $clog2(START_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(START_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_KICK, S_ACTIVE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] holdcnt_q, holdcnt_d;
    logic [2:0]    stopcnt_q, stopcnt_d;
    logic [2:0]    stoplen_q, stoplen_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          fifo_rd_q, fifo_rd_d;
    logic          txstart_q, txstart_d;
    logic          thre_q, thre_d;
    logic          thre_dly_q;
    logic          temt_q, temt_d;

    logic          go;
    logic          load;
    logic [HW-1:0] hold_inc;
    logic [2:0]    stop_inc;
    logic [2:0]    stoplen_sel;

    assign go = !FIFO_EMPTY && !CLEAR && (!AFE || CTS);

    // Both counters saturate so a stray extra tick can never wrap them back into range.
    assign hold_inc = (holdcnt_q == HOLD_MAX) ? holdcnt_q : holdcnt_q + 1'b1;
    assign stop_inc = (stopcnt_q == 3'd7) ? 3'd7 : stopcnt_q + 3'd1;

    // Baud ticks left after TXFINISHED before the line is idle. TXFINISHED marks entry to
    // the first stop bit, and the tick that coincides with it is not counted.
    assign stoplen_sel = !STB ? 3'd2 : ((WLS == 2'b00) ? 3'd3 : 3'd4);

    // State and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            holdcnt_q  <= '0;
            stopcnt_q  <= '0;
            stoplen_q  <= 3'd2;
            dout_q     <= '0;
            fifo_rd_q  <= 1'b0;
            txstart_q  <= 1'b0;
            thre_q     <= 1'b1;
            thre_dly_q <= 1'b1;
            temt_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            holdcnt_q  <= holdcnt_d;
            stopcnt_q  <= stopcnt_d;
            stoplen_q  <= stoplen_d;
            dout_q     <= dout_d;
            fifo_rd_q  <= fifo_rd_d;
            txstart_q  <= txstart_d;
            thre_q     <= thre_d;
            thre_dly_q <= thre_q;
            temt_q     <= temt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        holdcnt_d = holdcnt_q;
        stopcnt_d = stopcnt_q;
        stoplen_d = stoplen_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                load = go;
            end
            S_KICK: begin
                if (TXCLK) begin
                    holdcnt_d = hold_inc;
                    if (hold_inc == HOLD_MAX) begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (TXFINISHED) begin
                    if (go) begin
                        load = 1'b1;
                    end else begin
                        state_d   = S_DRAIN;
                        stopcnt_d = '0;
                        stoplen_d = stoplen_sel;
                    end
                end
            end
            S_DRAIN: begin
                // A new byte restarts immediately, even if the stop bits are about to end.
                if (go) begin
                    load = 1'b1;
                end else if (TXCLK) begin
                    stopcnt_d = stop_inc;
                    if (stop_inc >= stoplen_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            state_d   = S_KICK;
            holdcnt_d = '0;
        end
    end

    // Output logic. TXSTART is registered from the next state, so it is exactly
    // "state is KICK" and cannot leak into ACTIVE, IDLE or DRAIN.
    always_comb begin
        fifo_rd_d = load;
        dout_d    = load ? FIFO_DATA : dout_q;
        txstart_d = (state_d == S_KICK);
        thre_d    = FIFO_EMPTY;
        temt_d    = FIFO_EMPTY && (state_q == S_IDLE);
    end

    assign FIFO_RD = fifo_rd_q;
    assign TXSTART = txstart_q;
    assign DOUT    = dout_q;
    assign THRE    = thre_q;
    assign TEMT    = temt_q;
    assign THRI    = thre_q && !thre_dly_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       TXCLK;
    logic [1:0] WLS;
    logic       STB;
    logic       AFE;
    logic       CTS;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_DATA;
    logic       FIFO_RD;
    logic       CLEAR;
    logic       TXFINISHED;
    logic       TXSTART;
    logic [7:0] DOUT;
    logic       THRE;
    logic       TEMT;
    logic       THRI;

    uart_tx_scheduler #(.DW(8), .START_HOLD(4)) dut (
        .CLK(CLK), .RST(RST), .TXCLK(TXCLK), .WLS(WLS), .STB(STB), .AFE(AFE), .CTS(CTS),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_RD(FIFO_RD), .CLEAR(CLEAR),
        .TXFINISHED(TXFINISHED), .TXSTART(TXSTART), .DOUT(DOUT),
        .THRE(THRE), .TEMT(TEMT), .THRI(THRI)
    );

    always #5 CLK = ~CLK;

    logic [7:0] fq[$];
    int n_checks = 0;
    int n_err    = 0;
    int rd_cnt, thri_cnt, temt_seen, txs_seen, hi_pulses;
    int n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd();
        FIFO_EMPTY = (fq.size() == 0);
        FIFO_DATA  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        upd();
    endtask

    task automatic clr_acc();
        rd_cnt = 0; thri_cnt = 0; temt_seen = 0; txs_seen = 0; hi_pulses = 0;
    endtask

    // One clock cycle with the given TXCLK / TXFINISHED levels; outputs are observed 1ns after the edge.
    task automatic cyc(input logic tx, input logic fin);
        TXCLK      = tx;
        TXFINISHED = fin;
        if (tx && TXSTART) hi_pulses++;
        @(posedge CLK);
        #1;
        TXCLK      = 1'b0;
        TXFINISHED = 1'b0;
        if (FIFO_RD) begin
            rd_cnt++;
            if (fq.size() > 0) fq.delete(0);
        end
        if (CLEAR) fq.delete();
        if (THRI) thri_cnt++;
        if (TEMT) temt_seen++;
        if (TXSTART) txs_seen++;
        upd();
    endtask

    // Number of baud ticks after TXFINISHED until TEMT shows the line idle (0 = never within 8).
    task automatic drain_len(output int len);
        len = 0;
        for (int k = 1; k <= 8; k++) begin
            if (len == 0) begin
                cyc(1'b1, 1'b0);
                cyc(1'b0, 1'b0);
                if (TEMT) len = k;
            end
        end
    endtask

    initial begin
        RST = 1'b1; TXCLK = 1'b0; WLS = 2'b11; STB = 1'b0; AFE = 1'b0; CTS = 1'b0;
        CLEAR = 1'b0; TXFINISHED = 1'b0;
        upd();
        #22;
        check("rst_fifo_rd", FIFO_RD, 1'b0);
        check("rst_txstart", TXSTART, 1'b0);
        check("rst_dout",    DOUT,    8'h00);
        check("rst_thre",    THRE,    1'b1);
        check("rst_temt",    TEMT,    1'b1);
        check("rst_thri",    THRI,    1'b0);
        RST = 1'b0;

        // Single byte 0xA5, 8N1
        clr_acc();
        push(8'hA5);
        cyc(1'b0, 1'b0);
        check("t1_rd",      FIFO_RD, 1'b1);
        check("t1_dout",    DOUT,    8'hA5);
        check("t1_txstart", TXSTART, 1'b1);
        repeat (6) cyc(1'b1, 1'b0);
        check("t1_hold_pulses", hi_pulses, 4);
        check("t1_txstart_off", TXSTART, 1'b0);
        check("t1_rd_count",    rd_cnt,  1);
        check("t1_thri_count",  thri_cnt, 1);
        cyc(1'b0, 1'b1);
        check("t1_temt_fin", TEMT, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("t1_temt_2nd_tick", TEMT, 1'b0);
        cyc(1'b0, 1'b0);
        check("t1_temt_idle", TEMT, 1'b1);
        check("t1_dout_hold", DOUT, 8'hA5);

        // Three bytes back to back
        clr_acc();
        push(8'h11); push(8'h22); push(8'h33);
        cyc(1'b0, 1'b0);
        check("t2_rd0",   FIFO_RD, 1'b1);
        check("t2_dout0", DOUT,    8'h11);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("t2_rd1",   FIFO_RD, 1'b1);
        check("t2_dout1", DOUT,    8'h22);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("t2_rd2",   FIFO_RD, 1'b1);
        check("t2_dout2", DOUT,    8'h33);
        check("t2_thri_before", thri_cnt, 0);
        cyc(1'b1, 1'b0);
        check("t2_thri_pulse", THRI, 1'b1);
        repeat (3) cyc(1'b1, 1'b0);
        check("t2_thri_count", thri_cnt,  1);
        check("t2_temt_low",   temt_seen, 0);
        check("t2_rd_count",   rd_cnt,    3);
        cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("t2_temt_end", TEMT, 1'b1);

        // Auto flow control
        clr_acc();
        AFE = 1'b1; CTS = 1'b0;
        push(8'h44); push(8'h55);
        repeat (3) cyc(1'b0, 1'b0);
        check("t3_blocked_rd",  rd_cnt,   0);
        check("t3_blocked_txs", txs_seen, 0);
        CTS = 1'b1;
        cyc(1'b0, 1'b0);
        check("t3_cts_rd",   FIFO_RD, 1'b1);
        check("t3_cts_dout", DOUT,    8'h44);
        CTS = 1'b0;
        hi_pulses = 0;
        repeat (4) cyc(1'b1, 1'b0);
        check("t3_frame_completes", hi_pulses, 4);
        cyc(1'b0, 1'b1);
        check("t3_no_pop_fin", FIFO_RD, 1'b0);
        repeat (2) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        check("t3_wait_rd_count", rd_cnt, 1);
        check("t3_dout_kept",     DOUT,   8'h44);
        CTS = 1'b1;
        cyc(1'b0, 1'b0);
        check("t3_cts2_rd",   FIFO_RD, 1'b1);
        check("t3_cts2_dout", DOUT,    8'h55);
        AFE = 1'b0;
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        // Stop length from WLS/STB sampled at TXFINISHED
        WLS = 2'b00; STB = 1'b1;
        push(8'h66);
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        drain_len(n);
        check("t4_drain_5bit_stb", n, 3);
        WLS = 2'b10; STB = 1'b1;
        push(8'h67);
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        WLS = 2'b00; STB = 1'b0;
        drain_len(n);
        check("t4_drain_7bit_stb", n, 4);

        // New byte during DRAIN at stopcnt=1
        WLS = 2'b11; STB = 1'b0;
        push(8'h77);
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        clr_acc();
        push(8'h88);
        cyc(1'b0, 1'b0);
        check("t5_rd",      FIFO_RD, 1'b1);
        check("t5_dout",    DOUT,    8'h88);
        check("t5_txstart", TXSTART, 1'b1);
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("t5_temt_never", temt_seen, 0);
        repeat (2) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        // CLEAR with GO, then reset during KICK
        clr_acc();
        push(8'h99);
        CLEAR = 1'b1;
        cyc(1'b0, 1'b0);
        CLEAR = 1'b0;
        check("t6_clear_rd",      FIFO_RD, 1'b0);
        check("t6_clear_txstart", TXSTART, 1'b0);
        push(8'hAA);
        cyc(1'b0, 1'b0);
        check("t6_kick_txstart", TXSTART, 1'b1);
        check("t6_kick_dout",    DOUT,    8'hAA);
        cyc(1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        check("t6_arst_txstart", TXSTART, 1'b0);
        check("t6_arst_rd",      FIFO_RD, 1'b0);
        check("t6_arst_dout",    DOUT,    8'h00);
        check("t6_arst_thre",    THRE,    1'b1);
        check("t6_arst_temt",    TEMT,    1'b1);
        check("t6_arst_thri",    THRI,    1'b0);
        #3;
        RST = 1'b0;
        clr_acc();
        repeat (3) cyc(1'b1, 1'b0);
        check("t6_post_rst_txs", txs_seen, 0);
        check("t6_post_rst_rd",  rd_cnt,   0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
